// File: rtl/dec2bin_pkg.sv
// Shared types and constants for the BCD-to-binary sequencer and its mul10 unit.
//   state_e   : controller states
//   RES_W     : width of the binary result
//   PROD_W    : width of the mul10 product
//   RES_MAX   : saturation value of the result
//   DIGIT_MAX : largest legal BCD digit
package dec2bin_pkg;

  localparam int unsigned RES_W   = 16;
  localparam int unsigned PROD_W  = 32;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [RES_W-1:0]   RES_MAX   = 16'hFFFF;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    REL  = 3'd3,
    ADD  = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage : dec2bin_pkg

// File: rtl/bcd2bin_ctrl_if.sv
// Request/result bus of the BCD-to-binary sequencer.
//   master : requester side (drives ap_start, bcd_in)
//   slave  : sequencer side (drives ap_ready, ap_done, ap_return, ovf, err)
// NDIGITS sets the number of packed BCD digits carried on bcd_in.
interface bcd2bin_ctrl_if
  import dec2bin_pkg::*;
#(
  parameter int unsigned NDIGITS = 5
) ();

  localparam int unsigned BCD_W = DIGIT_W * NDIGITS;

  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic [BCD_W-1:0] bcd_in;
  logic [RES_W-1:0] ap_return;
  logic             ovf;
  logic             err;

  modport master (
    output ap_start,
    output bcd_in,
    input  ap_ready,
    input  ap_done,
    input  ap_return,
    input  ovf,
    input  err
  );

  modport slave (
    input  ap_start,
    input  bcd_in,
    output ap_ready,
    output ap_done,
    output ap_return,
    output ovf,
    output err
  );

endinterface : bcd2bin_ctrl_if

// File: rtl/mul10.sv
// Multiply-by-ten unit with a four-phase ap_start/ap_done handshake.
//   ap_clk, ap_rst (async, active-high)
//   ap_start  : level request, must stay high until ap_done is seen
//   n         : operand, sampled when the product is formed
//   ap_done   : product valid; rises on the third edge that samples ap_start
//               high, clears on the first edge that samples ap_start low
//   ap_return : n*10, 32 bit, held while ap_done=1
module mul10
  import dec2bin_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [RES_W-1:0]  n,
  output logic              ap_done,
  output logic [PROD_W-1:0] ap_return
);

  localparam int unsigned       CNT_W    = 2;
  localparam logic [CNT_W-1:0]  CNT_LAST = 2'd2;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [PROD_W-1:0] ret_q, ret_d;
  logic [PROD_W-1:0] prod_c;

  // n*10 as n*8 + n*2
  assign prod_c = (PROD_W'(n) << 3) + (PROD_W'(n) << 1);

  // Latency counter and four-phase done/release
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    ret_d  = ret_q;
    if (!ap_start) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
        ret_d  = prod_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      ret_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      ret_q  <= ret_d;
    end
  end

  assign ap_done   = done_q;
  assign ap_return = ret_q;

endmodule : mul10

// File: rtl/bcd2bin_ctrl.sv
// Packed-BCD to 16-bit binary sequencer. Horner iteration acc = acc*10 + digit,
// most-significant digit first, one mul10 handshake per digit. Results above
// 65535 saturate to 0xFFFF with a sticky ovf.
//   ap_clk, ap_rst_n (async, active-low)
//   ap_if (slave): ap_start/ap_ready/ap_done handshake, bcd_in, ap_return, ovf, err
//   NDIGITS      : number of BCD digits (1..5)
// Optional build macro DEC2BIN_DIGIT_CHECK_EN: a digit above 9 aborts the
// conversion with err=1, ap_return=0, ovf=0. Without it err is tied low and
// nibbles 10..15 are accumulated with their raw value.
module bcd2bin_ctrl
  import dec2bin_pkg::*;
#(
  parameter int unsigned NDIGITS = 5
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  bcd2bin_ctrl_if.slave ap_if
);

  localparam int unsigned BCD_W = DIGIT_W * NDIGITS;
  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_e            state_q, state_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              m_start_q, m_start_d;

  logic              m_done;
  logic [PROD_W-1:0] m_return;
  logic              mul_rst;

  logic [DIGIT_W-1:0] digit_c;
  logic [PROD_W-1:0]  sum_c;

`ifdef DEC2BIN_DIGIT_CHECK_EN
  logic               err_q, err_d;
  logic [DIGIT_W-1:0] top_digit_c;

  assign top_digit_c = ap_if.bcd_in[BCD_W-1 -: DIGIT_W];
`endif

  // Current digit: captured word shifted down by idx nibbles
  assign digit_c = DIGIT_W'(bcd_q >> (32'(idx_q) << 2));
  assign sum_c   = prod_q + PROD_W'(digit_c);

  assign mul_rst = ~ap_rst_n;

  mul10 u_mul10 (
    .ap_clk    (ap_clk),
    .ap_rst    (mul_rst),
    .ap_start  (m_start_q),
    .n         (acc_q),
    .ap_done   (m_done),
    .ap_return (m_return)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
`ifdef DEC2BIN_DIGIT_CHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (ap_if.ap_start) state_d = LOAD;
      end

      LOAD: begin
        bcd_d   = ap_if.bcd_in;
        acc_d   = '0;
        idx_d   = IDX_W'(NDIGITS - 1);
        ovf_d   = 1'b0;
        state_d = MUL;
`ifdef DEC2BIN_DIGIT_CHECK_EN
        err_d = 1'b0;
        // Top digit is checked here so a bad leading digit skips the multiply
        if (top_digit_c > DIGIT_MAX) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end

      MUL: begin
        if (m_done) begin
          prod_d  = m_return;
          state_d = REL;
        end
      end

      REL: begin
        if (!m_done) state_d = ADD;
      end

      ADD: begin
        // Saturation is absorbing: 0xFFFF*10 overflows again on later digits
        if (sum_c > PROD_W'(RES_MAX)) begin
          acc_d = RES_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum_c[RES_W-1:0];
        end
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = MUL;
        end
`ifdef DEC2BIN_DIGIT_CHECK_EN
        if (digit_c > DIGIT_MAX) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        // done is raised one cycle into DONE and released once ap_start is low
        done_d = 1'b1;
        if (done_q && !ap_if.ap_start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    m_start_d = (state_d == MUL);
    ready_d   = (state_d == IDLE) && !ap_if.ap_start;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      m_start_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      m_start_q <= m_start_d;
    end
  end

`ifdef DEC2BIN_DIGIT_CHECK_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign ap_if.err = err_q;
`else
  assign ap_if.err = 1'b0;
`endif

  assign ap_if.ap_ready  = ready_q;
  assign ap_if.ap_done   = done_q;
  assign ap_if.ap_return = acc_q;
  assign ap_if.ovf       = ovf_q;

endmodule : bcd2bin_ctrl

// File: tb/tb_bcd2bin_ctrl.sv
// Self-checking bench for bcd2bin_ctrl: directed cases plus randomized requests
// compared against a decimal-value reference model.
module tb_bcd2bin_ctrl;

  localparam int unsigned ND      = 5;
  localparam int unsigned BCD_W   = 4 * ND;
  localparam int unsigned TIMEOUT = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  bcd2bin_ctrl_if #(.NDIGITS(ND)) dut_if ();

  bcd2bin_ctrl #(.NDIGITS(ND)) u_dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ap_if    (dut_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish on its own");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal value of the digits, saturated; latency from the
  // documented timing (sample edge + LOAD + 7 cycles per digit + DONE entry).
  function automatic void ref_conv(input logic [BCD_W-1:0] bcd,
                                   output logic [15:0] val, output logic ovf,
                                   output logic err, output int lat);
    longint unsigned total;
    longint unsigned weight;
    logic [BCD_W-1:0] sh;
`ifdef DEC2BIN_DIGIT_CHECK_EN
    int bad;
    bad = -1;
`endif
    total  = 0;
    weight = 1;
    for (int p = 0; p < ND; p++) begin
      int unsigned d;
      sh     = bcd >> (4 * p);
      d      = 32'(sh[3:0]);
      total  = total + 64'(d) * weight;
      weight = weight * 10;
`ifdef DEC2BIN_DIGIT_CHECK_EN
      if (d > 9) bad = ND - 1 - p;
`endif
    end
    err = 1'b0;
    ovf = (total > 65535);
    val = ovf ? 16'hFFFF : 16'(total);
    lat = 2 + 7 * ND;
`ifdef DEC2BIN_DIGIT_CHECK_EN
    if (bad >= 0) begin
      err = 1'b1;
      ovf = 1'b0;
      val = 16'h0000;
      lat = (bad == 0) ? 2 : 2 + 7 * (bad + 1);
    end
`endif
  endfunction

  // One request; pulse=1 drops ap_start right after it is sampled
  task automatic do_conv(input logic [BCD_W-1:0] bcd, input bit pulse, input string tag);
    logic [15:0] e_val;
    logic        e_ovf, e_err;
    int          e_lat;
    int          n;
    bit          seen;
    ref_conv(bcd, e_val, e_ovf, e_err, e_lat);
    @(negedge clk);
    check_eq({tag, ".ready_idle"}, 32'(dut_if.ap_ready), 32'd1);
    dut_if.bcd_in   = bcd;
    dut_if.ap_start = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, ".ready_busy"}, 32'(dut_if.ap_ready), 32'd0);
    if (pulse) begin
      @(negedge clk);
      dut_if.ap_start = 1'b0;
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
      seen = dut_if.ap_done;
    end
    check_eq({tag, ".latency"}, 32'(n), 32'(e_lat));
    check_eq({tag, ".ap_return"}, 32'(dut_if.ap_return), 32'(e_val));
    check_eq({tag, ".ovf"}, 32'(dut_if.ovf), 32'(e_ovf));
    check_eq({tag, ".err"}, 32'(dut_if.err), 32'(e_err));
    if (!pulse) begin
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, ".done_held"}, 32'(dut_if.ap_done), 32'd1);
      check_eq({tag, ".ret_stable"}, 32'(dut_if.ap_return), 32'(e_val));
      @(negedge clk);
      dut_if.ap_start = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".done_drop"}, 32'(dut_if.ap_done), 32'd0);
    check_eq({tag, ".ready_back"}, 32'(dut_if.ap_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".ready"}, 32'(dut_if.ap_ready), 32'd0);
    check_eq({tag, ".done"}, 32'(dut_if.ap_done), 32'd0);
    check_eq({tag, ".ret"}, 32'(dut_if.ap_return), 32'd0);
    check_eq({tag, ".ovf"}, 32'(dut_if.ovf), 32'd0);
    check_eq({tag, ".err"}, 32'(dut_if.err), 32'd0);
    check_eq({tag, ".m_start"}, 32'(u_dut.m_start_q), 32'd0);
  endtask

  // Reset asserted during the third digit's multiply
  task automatic reset_mid();
    @(negedge clk);
    dut_if.bcd_in   = 20'h98765;
    dut_if.ap_start = 1'b1;
    @(posedge clk);
    repeat (16) @(posedge clk);
    #1;
    check_eq("rst.pre_m_start", 32'(u_dut.m_start_q), 32'd1);
    check_eq("rst.pre_acc", 32'(dut_if.ap_return), 32'd98);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst.mid");
    @(negedge clk);
    dut_if.ap_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [BCD_W-1:0] v;
    dut_if.ap_start = 1'b0;
    dut_if.bcd_in   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_conv(20'h00123, 1'b0, "d123");
    do_conv(20'h65535, 1'b0, "d65535");
    do_conv(20'h65536, 1'b0, "d65536");
    do_conv(20'h99999, 1'b0, "d99999");
    do_conv(20'h1A234, 1'b0, "d1A234");
    do_conv(20'hB0001, 1'b0, "dB0001");
    do_conv(20'h00042, 1'b1, "pulse42");
    reset_mid();
    do_conv(20'h00007, 1'b0, "after_rst");
    do_conv(20'h99999, 1'b0, "b2b_ovf");
    do_conv(20'h00000, 1'b0, "b2b_zero");
    do_conv(20'h00010, 1'b0, "b2b_ten");

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: for (int k = 0; k < ND; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        1: v = BCD_W'($urandom);
        default: begin
          for (int k = 0; k < ND; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
          v[BCD_W-1 -: 4] = 4'($urandom_range(5, 9));
        end
      endcase
      do_conv(v, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bcd2bin_ctrl
